// File: rtl/fpu_issue_queue.sv
// Issue/retire wrapper around a fixed-latency, non-stallable FPU pipeline.
// Tracks tagged operands through the unit and buffers results behind a credit-limited FIFO.
`timescale 1ns/1ps
module fpu_issue_queue #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      unit_src,
    input  logic [31:0]      unit_dest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CREDITS  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               accept, pop, push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid_q & out_ready;
    assign push      = vld_q[LATENCY-1];
    assign unit_src  = accept ? in_data : '0;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_tag   = mem_q[rd_ptr_q].tag;

    // Next state: tracking shift register, credit counter, FIFO bookkeeping.
    always_comb begin
        vld_d       = '0;
        pending_d   = pending_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        for (int unsigned i = 0; i < LATENCY; i++) tag_d[i] = '0;

        vld_d[0] = accept;
        tag_d[0] = in_tag;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        if (accept && !pop)      pending_d = pending_q + CNT_W'(1);
        else if (!accept && pop) pending_d = pending_q - CNT_W'(1);

        if (push && !pop)        count_d = count_q + CNT_W'(1);
        else if (!push && pop)   count_d = count_q - CNT_W'(1);

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        in_ready_d  = (pending_d < CREDITS);
        out_valid_d = (count_d != '0);
        busy_d      = (pending_d != '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q       <= '0;
            pending_q   <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Tags and result storage carry no reset; their validity lives in vld_q/count_q.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        if (push) mem_q[wr_ptr_q] <= '{data: unit_dest, tag: tag_q[LATENCY-1]};
    end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: attached fsqrt pipeline model, handshake-driven scoreboard,
// directed scenarios and a randomized regression.
`timescale 1ns/1ps
module tb_fpu_issue_queue;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0]      in_data, unit_src, unit_dest, out_data;
    logic [TAG_W-1:0] in_tag, out_tag;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_pop = 0;
    logic rnd_ready = 1'b0;
    logic [32+TAG_W-1:0] exp_q [$];
    logic [31:0] pipe [LATENCY];

    fpu_issue_queue #(.LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .unit_src(unit_src), .unit_dest(unit_dest),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Correctly rounded single-precision sqrt for positive normal operands, integer arithmetic.
    function automatic logic [31:0] fsqrt_ref(input logic [31:0] x);
        int ue, s, ex;
        logic [63:0] n, r, c;
        if (x[31] || x[30:23] == 8'h00 || x[30:23] == 8'hFF) return 32'h0;
        ue = int'(x[30:23]) - 150;
        s  = (((ue - 23) % 2) == 0) ? 23 : 24;
        n  = {40'b0, 1'b1, x[22:0]} << s;
        r  = 64'd0;
        for (int b = 24; b >= 0; b--) begin
            c = r | (64'd1 << b);
            if (c * c <= n) r = c;
        end
        if (n > r * r + r) r = r + 64'd1;
        ex = 150 + (ue - s) / 2;
        return {1'b0, ex[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    // Free-running fsqrt stand-in: result of the operand sampled LATENCY edges earlier.
    always @(posedge clk) begin
        pipe[0] <= fsqrt_ref(unit_src);
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign unit_dest = pipe[LATENCY-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Issue side: credit rule from handshake counts, and expected result enqueue.
    always @(negedge clk) begin
        int   pend;
        logic rdy;
        if (!rstn) begin
            n_acc <= 0;
        end else begin
            pend = n_acc - n_pop;
            rdy  = (pend < int'(DEPTH));
            chk("in_ready", 64'(in_ready), 64'(rdy));
            chk("busy", 64'(busy), 64'(pend != 0));
            chk("unit_src", 64'(unit_src), 64'((in_valid && rdy) ? in_data : 32'h0));
            if (in_valid && in_ready) begin
                exp_q.push_back({fsqrt_ref(in_data), in_tag});
                n_acc <= n_acc + 1;
            end
        end
    end

    // Retire side: pop expected on every handshake, and check hold stability under backpressure.
    always @(negedge clk) begin
        logic                held;
        logic [32+TAG_W-1:0] held_v, e;
        if (!rstn) begin
            n_pop <= 0;
            held  = 1'b0;
        end else begin
            if (held) begin
                total++;
                if (!out_valid || {out_data, out_tag} !== held_v) begin
                    bad++;
                    $display("FAIL hold: got v=%b %h/%h expected %h/%h", out_valid, out_data, out_tag,
                             held_v[32+TAG_W-1:TAG_W], held_v[TAG_W-1:0]);
                end
            end
            held   = out_valid && !out_ready;
            held_v = {out_data, out_tag};
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL result: got %h/%h expected no result", out_data, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_tag} !== e) begin
                        bad++;
                        $display("FAIL result: got %h/%h expected %h/%h", out_data, out_tag,
                                 e[32+TAG_W-1:TAG_W], e[TAG_W-1:0]);
                    end
                end
                n_pop <= n_pop + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t);
        logic acc;
        int   n = 0;
        in_valid = 1'b1; in_data = d; in_tag = t;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        in_valid = 1'b0; in_data = 32'h0;
        chk("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || out_valid) && n < 300) begin
            tick();
            n++;
        end
        chk(nm, 64'({busy, out_valid}), 64'd0);
    endtask

    initial begin
        int p0, a0;
        logic acc;
        logic [TAG_W-1:0] t;

        rstn = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_unit_src", 64'(unit_src), 64'd0);
        rstn = 1'b1;
        tick();

        // Single op: sqrt(4.0) with tag 3.
        in_valid = 1'b1; in_data = 32'h40800000; in_tag = 5'd3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 32'h0;
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_early0", 64'(out_valid), 64'd0);
        for (int k = 1; k < LATENCY; k++) begin
            tick();
            chk("single_early", 64'(out_valid), 64'd0);
        end
        tick();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", 64'(out_data), 64'h40000000);
        chk("single_tag", 64'(out_tag), 64'd3);
        chk("single_busy_q", 64'(busy), 64'd1);
        tick();
        chk("single_done_valid", 64'(out_valid), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);

        // Back-to-back stream of 16 operands.
        p0 = n_pop;
        for (int i = 0; i < 16; i++) send(rand_op(), TAG_W'(i));
        wait_idle("b2b_drain");
        chk("b2b_count", 64'(n_pop - p0), 64'd16);

        // Backpressure: six offered, four credits.
        out_ready = 1'b0;
        a0 = n_acc; p0 = n_pop;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = rand_op(); in_tag = TAG_W'(i);
            tick();
        end
        in_valid = 1'b0; in_data = 32'h0;
        chk("bp_accepts", 64'(n_acc - a0), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (LATENCY) tick();
        chk("bp_head_valid", 64'(out_valid), 64'd1);
        chk("bp_head_tag", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        repeat (4) tick();
        chk("bp_drained", 64'(n_pop - p0), 64'd4);
        chk("bp_idle", 64'({busy, out_valid}), 64'd0);

        // Full FIFO, then concurrent accept and pop with pointer wrap.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(rand_op(), TAG_W'(i));
        repeat (LATENCY + 1) tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        a0 = n_acc; p0 = n_pop;
        out_ready = 1'b1;
        t = 5'd10;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = rand_op(); in_tag = t;
            acc = in_ready;
            tick();
            if (acc) t = t + 5'd1;
        end
        in_valid = 1'b0; in_data = 32'h0;
        wait_idle("wrap_drain");
        chk("wrap_balance", 64'((n_pop - p0) - (n_acc - a0)), 64'(DEPTH));

        // Reset with two results queued and two still in the unit.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_op(), TAG_W'(20 + i));
        tick();
        tick();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_quiet", 64'(out_valid), 64'd0);
        end

        // Random regression.
        rnd_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(rand_op(), TAG_W'($urandom));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_idle("rand_drain");
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
